// File: rtl/tdm_scan_mux_pkg.sv
// Shared types for the time-division scan multiplexer.
// Mode and FSM encodings are reused by the top and by any wrappers.
package tdm_scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int N_CH_DEF  = 16;
    localparam int WIDTH_DEF = 8;

    // Circular successor of a channel index inside an n-channel ring.
    function automatic int unsigned ring_next(
        input int unsigned cur,
        input int unsigned n
    );
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/tdm_scan_mux_find.sv
// Circular first-set search over a request mask, starting at a pointer.
// Rotate so start sits at bit 0, priority-encode, then rotate back.
module rr_find_next #(
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]  rot;
    logic [SEL_W:0]   base;
    logic [SEL_W:0]   pos;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] off;

    always_comb begin
        base = {1'b0, start};
        if (base >= N_W) begin
            base = '0;
        end

        rot = '0;
        pos = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = base + (SEL_W + 1)'(i);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            rot[i] = mask[pos[SEL_W-1:0]];
        end

        // Lowest set bit of the rotated mask wins.
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end

        found = |rot;

        sum = base + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/tdm_scan_mux.sv
// Registered N:1 channel mux with manual select or round-robin scan,
// presenting the chosen word and its index on a valid/ready port.
module tdm_scan_mux
    import tdm_scan_mux_pkg::*;
#(
    parameter  int N_CH  = 16,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] ch_data,
    input  logic [N_CH-1:0]       ch_en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      man_sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W:0]   N_W   = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_nxt;

    logic             scan_found;
    logic [SEL_W-1:0] scan_idx;
    logic             man_ok;
    logic             is_scan;

    logic             load;
    logic             cand_ok;
    logic [SEL_W-1:0] cand_ch;
    logic [WIDTH-1:0] cand_data;

    rr_find_next #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_find (
        .mask  (ch_en),
        .start (ptr_q),
        .found (scan_found),
        .idx   (scan_idx)
    );

    assign is_scan = (mode == MODE_SCAN);

    always_comb begin
        man_ok = 1'b0;
        if ({1'b0, man_sel} < N_W) begin
            man_ok = ch_en[man_sel];
        end
    end

    always_comb begin
        cand_ok = man_ok;
        cand_ch = man_sel;
        if (is_scan) begin
            cand_ok = scan_found;
            cand_ch = scan_idx;
        end
    end

    assign cand_data = ch_data[int'(cand_ch)*WIDTH +: WIDTH];
    assign ptr_nxt   = (cand_ch == LAST) ? '0 : cand_ch + 1'b1;

    // A held beat is replaced only when it is accepted or when empty.
    always_comb begin
        state_d = state_q;
        load    = (state_q == ST_EMPTY) || out_ready;
        if (load) begin
            state_d = cand_ok ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            ptr_q    <= '0;
        end else if (load && cand_ok) begin
            out_data <= cand_data;
            out_ch   <= cand_ch;
            if (is_scan) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);

endmodule

// File: doc/tdm_scan_mux.md
# tdm_scan_mux

Parametrised, registered N:1 channel multiplexer. It generalises the fixed 16:1 gate-level mux into a time-division scanner: it selects one of `N_CH` word-wide channels either by an explicit select or by automatic round-robin scanning over an enable mask. It presents the selected word and its channel index on a valid/ready output port. It sits between a bank of parallel sample sources and a single serial consumer (logger, UART framer, DMA).

## Interface
Parameters:
- `N_CH`, default 16: number of input channels; legal range 2..256.
- `WIDTH`, default 8: data bits per channel.
- `SEL_W`, localparam = `$clog2(N_CH)`: channel index width.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `ch_data`  in  `N_CH*WIDTH`  packed channel words; channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `ch_en`  in  `N_CH`  per-channel enable mask.
- `mode`  in  1  0 = MANUAL, 1 = SCAN.
- `man_sel`  in  `SEL_W`  channel selected in MANUAL mode.
- `out_data`  out  `WIDTH`  registered selected word.
- `out_ch`  out  `SEL_W`  index of the channel that produced `out_data`.
- `out_valid`  out  1  output beat available.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- Two-state FSM:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load condition: `load = (state==EMPTY) || out_ready`. A load captures a candidate channel's word and index into the output registers.
- Candidate selection:
  - MANUAL: candidate = `man_sel` if `man_sel < N_CH` and `ch_en[man_sel]`=1; otherwise none.
  - SCAN: candidate = first k with `ch_en[k]`=1, searched `ptr, ptr+1, …` modulo `N_CH`. The search includes `ptr` itself. If the mask is all zero, there is no candidate.
- On load with a candidate:
  - `out_data`/`out_ch` ← candidate; state → FULL.
  - In SCAN only, `ptr` ← (candidate+1) mod `N_CH`. Wrap from `N_CH-1` goes to 0.
- On load with no candidate: state → EMPTY; `out_data`/`out_ch` keep their last values.
- No load: all outputs and `ptr` hold. A beat presented with `out_valid`=1 stays bit-stable until accepted.
- `mode`, `man_sel` and `ch_en` changes affect only the next load, never a held beat. `ptr` is not modified in MANUAL mode. Returning to SCAN resumes from the retained `ptr`.
- A disabled channel is never emitted in SCAN, even if it is the one `ptr` points at.

## Timing
- Reset (`rst_n`=0 at rising edge):
  - `out_data`=0, `out_ch`=0, `out_valid`=0, `ptr`=0, state EMPTY.
  - Reset overrides any in-flight beat; that beat is dropped.
- Latency: one cycle. Inputs sampled at edge t appear on `out_data` after edge t.
- Throughput: one beat per cycle while `out_ready`=1 and a candidate exists. `out_valid` stays high back-to-back.
- Handshake:
  - A transfer occurs in a cycle with `out_valid && out_ready`.
  - Acceptance and the next load happen on the same edge, so there are no bubbles.
  - `out_valid` does not depend combinationally on `out_ready`.
- With `out_ready` tied high in SCAN, the enabled channels are emitted in ascending circular order, one per cycle.

## Structure
- Package `tdm_scan_mux_pkg`:
  - `mode_e` {MODE_MANUAL=1'b0, MODE_SCAN=1'b1}.
  - `state_e` {ST_EMPTY, ST_FULL}.
- Sub-module `rr_find_next`, combinational:
  - Inputs: `mask[N_CH]`, `start[SEL_W]`.
  - Outputs: `found`, `idx[SEL_W]`.
  - Implementation: rotate, priority-encode, unrotate.
  - It is reused by other arbiter blocks.
- Top-level contents: word extraction by indexed part-select, the FSM, `ptr`, and the output registers.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with arbitrary inputs → `out_valid`=0, `out_data`=0, `out_ch`=0. The first SCAN beat after release is from channel 0 when `ch_en`=16'hFFFF.
- SCAN, full mask, `out_ready`=1, `ch_data[k]`=k+8'h10 → `out_ch` sequence 0,1,…,15,0 with matching data 8'h10…8'h1F. `out_valid` stays continuously high.
- SCAN, sparse mask `ch_en`=16'h8021 → `out_ch` sequence 0,5,15,0,5. Wrap from 15 to 0 is correct; disabled channels are never emitted.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-scan while changing `ch_data` → `out_data`/`out_ch` stay frozen. On release, the held beat transfers, then the scan continues at the next enabled channel.
- MANUAL: `man_sel`=9, `ch_en[9]`=1, `ch_data[9]`=8'hA5 → repeated beats `out_ch`=9, `out_data`=8'hA5. Clearing `ch_en[9]` → `out_valid` falls after the current beat is accepted. Switching back to SCAN resumes at the retained `ptr`.
- Reset mid-operation: assert `rst_n`=0 while FULL and stalled → `out_valid`=0 on the next edge and `ptr`=0. The pending beat is never emitted.
